hazard_stall: RTL
=================

# hazard_stall

Stall-side counterpart of the pipeline's bypass network for the 5-stage MIPS core. Where forwarding consumes results already in flight, this block decides when a consumer in D cannot be served by any bypass path and must wait. It keeps a registered shadow of producer state for E and M, plus a multiply/divide busy counter. It drives the D-stage freeze and the E-stage bubble injection.

## Interface
- No parameters. MD latencies are package constants: `MD_MULT_CYC` = 5, `MD_DIV_CYC` = 10.
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low; 0 clears all state immediately.
- IR_D  input  32  instruction currently held in the D register.
- Stall_D  output  1  freeze PC and the D register this cycle.
- Flush_E  output  1  load a bubble (nop) into E at the next edge; always equals Stall_D.
- MDBusy  output  1  MD counter non-zero.
- MDStart_E  output  1  registered; 1 while E holds mult/multu/div/divu.

## Operation
- The decoder classifies IR_D. Outputs:
  - rs_use / rt_use flags and Tuse_rs / Tuse_rt (0..2).
  - Tnew at E entry (0..2), A3 (5 b), we, is_md, is_md_start, md_div.
- Tuse by instruction:
  - beq rs/rt = 0; jr rs = 0.
  - addu/subu/ori/lw/sw rs = 1; sw rt = 2.
  - mthi/mtlo rs = 1; mult/multu/div/divu rs/rt = 1.
- Tnew and A3 by instruction:
  - addu/subu/mfhi/mflo → Tnew 1, A3 = rd.
  - ori/lui → Tnew 1, A3 = rt.
  - lw → Tnew 2, A3 = rt.
  - jal → Tnew 0, A3 = 31.
  - All others → we = 0.
- Shadow registers SB_E and SB_M each hold {A3, Tnew, we}.
- At each edge:
  - SB_M ← SB_E with Tnew decremented, saturating at 0.
  - SB_E ← decoded D fields if Stall_D = 0, else a bubble (we = 0).
- Data stall for X ∈ {E, M}: we_X and A3_X ≠ 0 and, for rs or rt in use, reg == A3_X and Tuse < Tnew_X.
- MD stall, active only with `MD_STALL_EN`: is_md(IR_D) and MDBusy.
- Stall_D = data stall OR MD stall. The stall is combinational from IR_D and registered state, within the same cycle.
- MD counter (4 b):
  - Loads `MD_DIV_CYC` or `MD_MULT_CYC` at the edge where an MD-start instruction leaves D unstalled.
  - Otherwise decrements to 0 and holds there.
- Unknown opcodes decode as nop: no use, we = 0.

## Timing
- Reset values:
  - Stall_D = 0, Flush_E = 0, MDBusy = 0, MDStart_E = 0.
  - SB_E and SB_M hold bubbles; MD counter = 0.
- Reset asserted mid-stall: outputs drop to 0 asynchronously. The first instruction after release sees empty shadows.
- lw → dependent ALU op: 1 stall cycle. lw → beq/jr: 2 cycles. ALU op → beq/jr: 1 cycle. jal → jr $31: 0 cycles.
- mult → mflo: 5 stall cycles; div → mfhi: 10 stall cycles.
  - The counter is already non-zero in the first cycle the consumer sits in D.
- MD start back-to-back with another MD start: the second stalls until MDBusy = 0, then reloads its own count.
- Data stall and MD stall together: a single Stall_D; the shadow bubble is inserted once per stalled cycle.
- Writes to $0 never stall.

## Configuration
- `MD_STALL_EN` defined:
  - MD counter, MDBusy, MDStart_E and the MD stall term are present.
  - Stall-time behaviour follows the MD latency rules above.
- Not defined:
  - Counter logic is omitted; MDBusy and MDStart_E are tied to 0.
  - The MD stall term is 0.
  - Used for cores without a HI/LO unit.

## Structure
- Package `hazard_pkg`:
  - Opcode/funct constants.
  - Tuse/Tnew encodings.
  - `MD_MULT_CYC` and `MD_DIV_CYC`.
  - Shadow-entry struct {A3, Tnew, we}.
- Sub-module `hazard_decode`: purely combinational IR → class fields. This block instantiates it once, on IR_D.

## Test plan
- lw $8,0($0) then addu $9,$8,$8 → Stall_D = Flush_E = 1 for exactly 1 cycle, then 0.
- lw $8 then beq $8,$8 → Stall_D high for 2 consecutive cycles.
- ori $0,$0,1 then beq $0,$0 → Stall_D = 0 throughout; jal then jr $31 → Stall_D = 0.
- mult $1,$2 then mflo $3 → MDBusy counts 5,4,3,2,1; Stall_D = 1 for 5 cycles; MDStart_E = 1 for 1 cycle. Repeat with div → 10 cycles.
- Assert reset = 0 during the 2nd stall cycle of lw/beq → Stall_D, MDBusy = 0 immediately. After release, beq $8 issues without stall.
- Build without `MD_STALL_EN`, mult then mflo → Stall_D = 0, MDBusy = 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared decode constants, shadow-entry layout and latency constants for the D-stage stall logic.
// The optional HI/LO stall path is controlled by MD_STALL_EN.
package hazard_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  typedef logic [1:0] tcyc_t;
  localparam tcyc_t T_0 = 2'd0;
  localparam tcyc_t T_1 = 2'd1;
  localparam tcyc_t T_2 = 2'd2;

  localparam logic [3:0] MD_MULT_CYC = 4'd5;
  localparam logic [3:0] MD_DIV_CYC  = 4'd10;

  typedef struct packed {
    logic [4:0] a3;
    tcyc_t      tnew;
    logic       we;
  } sb_entry_t;

  localparam sb_entry_t SB_BUBBLE = '0;

  typedef struct packed {
    logic       rs_use;
    logic       rt_use;
    tcyc_t      tuse_rs;
    tcyc_t      tuse_rt;
    tcyc_t      tnew;
    logic [4:0] a3;
    logic       we;
    logic       is_md;
    logic       is_md_start;
    logic       md_div;
  } decode_t;

  // Consumer must wait when its read comes earlier than the producer's result.
  function automatic logic hazard_hit(logic use_r, logic [4:0] r, tcyc_t tuse, sb_entry_t sb);
    return use_r && sb.we && (sb.a3 != 5'd0) && (r == sb.a3) && (tuse < sb.tnew);
  endfunction

  function automatic tcyc_t tnew_dec(tcyc_t t);
    return (t == T_0) ? T_0 : tcyc_t'(t - 2'd1);
  endfunction

endpackage

// File: rtl/hazard_decode.sv
// Combinational classifier: instruction word -> operand use times, producer timing and MD class.
module hazard_decode
  import hazard_pkg::*;
(
  input  logic [31:0] ir,
  output decode_t     dec
);

  logic [5:0] op, fn;
  logic [4:0] rt, rd;

  assign op = ir[31:26];
  assign fn = ir[5:0];
  assign rt = ir[20:16];
  assign rd = ir[15:11];

  always_comb begin
    dec = '0;
    unique case (op)
      OP_RTYPE: begin
        unique case (fn)
          FN_ADDU, FN_SUBU: begin
            dec.rs_use = 1'b1;  dec.tuse_rs = T_1;
            dec.rt_use = 1'b1;  dec.tuse_rt = T_1;
            dec.we = 1'b1;  dec.tnew = T_1;  dec.a3 = rd;
          end
          FN_JR: begin
            dec.rs_use = 1'b1;  dec.tuse_rs = T_0;
          end
          FN_MFHI, FN_MFLO: begin
            dec.we = 1'b1;  dec.tnew = T_1;  dec.a3 = rd;
            dec.is_md = 1'b1;
          end
          FN_MTHI, FN_MTLO: begin
            dec.rs_use = 1'b1;  dec.tuse_rs = T_1;
            dec.is_md = 1'b1;
          end
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            dec.rs_use = 1'b1;  dec.tuse_rs = T_1;
            dec.rt_use = 1'b1;  dec.tuse_rt = T_1;
            dec.is_md = 1'b1;
            dec.is_md_start = 1'b1;
            dec.md_div = (fn == FN_DIV) || (fn == FN_DIVU);
          end
          default: ;
        endcase
      end
      OP_ORI: begin
        dec.rs_use = 1'b1;  dec.tuse_rs = T_1;
        dec.we = 1'b1;  dec.tnew = T_1;  dec.a3 = rt;
      end
      OP_LUI: begin
        dec.we = 1'b1;  dec.tnew = T_1;  dec.a3 = rt;
      end
      OP_LW: begin
        dec.rs_use = 1'b1;  dec.tuse_rs = T_1;
        dec.we = 1'b1;  dec.tnew = T_2;  dec.a3 = rt;
      end
      OP_SW: begin
        dec.rs_use = 1'b1;  dec.tuse_rs = T_1;
        dec.rt_use = 1'b1;  dec.tuse_rt = T_2;
      end
      OP_BEQ: begin
        dec.rs_use = 1'b1;  dec.tuse_rs = T_0;
        dec.rt_use = 1'b1;  dec.tuse_rt = T_0;
      end
      OP_JAL: begin
        dec.we = 1'b1;  dec.tnew = T_0;  dec.a3 = 5'd31;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_stall.sv
// D-stage stall/E-stage flush generator from E/M producer shadows and an optional MD busy counter.
// Define MD_STALL_EN to include the HI/LO busy counter and its stall term.
module hazard_stall
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_D,
  output logic        Stall_D,
  output logic        Flush_E,
  output logic        MDBusy,
  output logic        MDStart_E
);

  decode_t    dec;
  sb_entry_t  sb_e, sb_m, sb_d;
  logic [4:0] rs, rt;
  logic       data_stall, md_stall;

  hazard_decode u_dec (.ir(IR_D), .dec(dec));

  assign rs = IR_D[25:21];
  assign rt = IR_D[20:16];

  assign data_stall = hazard_hit(dec.rs_use, rs, dec.tuse_rs, sb_e)
                    | hazard_hit(dec.rt_use, rt, dec.tuse_rt, sb_e)
                    | hazard_hit(dec.rs_use, rs, dec.tuse_rs, sb_m)
                    | hazard_hit(dec.rt_use, rt, dec.tuse_rt, sb_m);

  assign Stall_D = data_stall | md_stall;
  assign Flush_E = Stall_D;

  assign sb_d = '{a3: dec.a3, tnew: dec.tnew, we: dec.we};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sb_e <= SB_BUBBLE;
      sb_m <= SB_BUBBLE;
    end else begin
      sb_m <= '{a3: sb_e.a3, tnew: tnew_dec(sb_e.tnew), we: sb_e.we};
      sb_e <= Stall_D ? SB_BUBBLE : sb_d;
    end
  end

`ifdef MD_STALL_EN
  logic [3:0] md_cnt;

  assign MDBusy   = (md_cnt != 4'd0);
  assign md_stall = dec.is_md & MDBusy;

  // A new MD op can only leave D once the counter has drained, so a load never overlaps a count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_cnt    <= 4'd0;
      MDStart_E <= 1'b0;
    end else begin
      MDStart_E <= dec.is_md_start & ~Stall_D;
      if (dec.is_md_start && !Stall_D)
        md_cnt <= dec.md_div ? MD_DIV_CYC : MD_MULT_CYC;
      else if (md_cnt != 4'd0)
        md_cnt <= 4'(md_cnt - 4'd1);
    end
  end
`else
  logic unused_md;

  assign unused_md = ^{dec.is_md, dec.is_md_start, dec.md_div};
  assign MDBusy    = 1'b0;
  assign MDStart_E = 1'b0;
  assign md_stall  = 1'b0;
`endif

endmodule
